// File: rtl/pipelined_cla_addsub_if.sv
// Operand-issue / writeback handshake bundle for the pipelined CLA add/subtract unit.
// The master side issues operands and accepts results; the slave side is the arithmetic unit.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero, negative
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead add/subtract unit: one SEG-bit segment per stage, carry registered
// between stages, flags formed in the last stage, whole pipe stalls when the result is not taken.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_cla_addsub_if.slave bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLOCK;
  localparam int L    = STAGES - 1;

  if (WIDTH % (STAGES * BLOCK) != 0) begin : g_bad_geometry
    $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES*BLOCK");
  end

  // One segment: BLOCK-bit lookahead groups whose group carries ripple into the next group.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic [SEG-1:0]   s;
    logic             gc;
    logic             term;
    g    = '0;
    p    = '0;
    c    = '0;
    s    = '0;
    gc   = ci;
    term = 1'b0;
    for (int grp = 0; grp < NGRP; grp++) begin
      g = x[grp*BLOCK +: BLOCK] & y[grp*BLOCK +: BLOCK];
      p = x[grp*BLOCK +: BLOCK] ^ y[grp*BLOCK +: BLOCK];
      for (int i = 0; i <= BLOCK; i++) begin
        c[i] = gc;
        for (int j = 0; j < i; j++) begin
          c[i] = c[i] & p[j];
        end
        for (int j = 0; j < i; j++) begin
          term = g[j];
          for (int k = j + 1; k < i; k++) begin
            term = term & p[k];
          end
          c[i] = c[i] | term;
        end
      end
      s[grp*BLOCK +: BLOCK] = p ^ c[BLOCK-1:0];
      gc = c[BLOCK];
    end
    return {gc, s};
  endfunction

  logic             lv_valid [STAGES];
  logic [1:0]       lv_op    [STAGES];
  logic [WIDTH-1:0] lv_a     [STAGES];
  logic [WIDTH-1:0] lv_b     [STAGES];
  logic [WIDTH-1:0] lv_s     [STAGES];
  logic             lv_c     [STAGES];

  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             overflow_r;
  logic             zero_r;
  logic             negative_r;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // A single global enable: nothing moves while a finished result waits on the writeback side.
  assign advance = ~out_valid_r | bus.out_ready;
  assign b_eff   = bus.op[0] ? ~bus.b : bus.b;
  assign c0      = bus.op[1] ? (bus.cin ^ bus.op[0]) : bus.op[0];

  logic [SEG:0]     seg_r;
  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];

  always_comb begin
    seg_r = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_r                 = seg_add(lv_a[k][k*SEG +: SEG], lv_b[k][k*SEG +: SEG], lv_c[k]);
      nx_s[k]               = lv_s[k];
      nx_s[k][k*SEG +: SEG] = seg_r[SEG-1:0];
      nx_c[k]               = seg_r[SEG];
    end
  end

  logic [WIDTH-1:0] fin_sum;
  logic             fin_carry;
  logic             fin_ovf;

  // Subtract ops report borrow, which is the inverse of the raw adder carry.
  assign fin_sum   = nx_s[L];
  assign fin_carry = nx_c[L] ^ lv_op[L][0];
  assign fin_ovf   = (lv_a[L][WIDTH-1] == lv_b[L][WIDTH-1]) &&
                     (fin_sum[WIDTH-1] != lv_a[L][WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        lv_valid[k] <= 1'b0;
        lv_op[k]    <= '0;
        lv_a[k]     <= '0;
        lv_b[k]     <= '0;
        lv_s[k]     <= '0;
        lv_c[k]     <= 1'b0;
      end
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      carry_r     <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      negative_r  <= 1'b0;
    end else if (advance) begin
      lv_valid[0] <= bus.in_valid;
      if (bus.in_valid) begin
        lv_op[0] <= bus.op;
        lv_a[0]  <= bus.a;
        lv_b[0]  <= b_eff;
        lv_s[0]  <= '0;
        lv_c[0]  <= c0;
      end
      for (int k = 1; k < STAGES; k++) begin
        lv_valid[k] <= lv_valid[k-1];
        lv_op[k]    <= lv_op[k-1];
        lv_a[k]     <= lv_a[k-1];
        lv_b[k]     <= lv_b[k-1];
        lv_s[k]     <= nx_s[k-1];
        lv_c[k]     <= nx_c[k-1];
      end
      out_valid_r <= lv_valid[L];
      sum_r       <= fin_sum;
      carry_r     <= fin_carry;
      overflow_r  <= fin_ovf;
      zero_r      <= (fin_sum == '0);
      negative_r  <= fin_sum[WIDTH-1];
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.carry     = carry_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
  assign bus.negative  = negative_r;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub (32-bit, 2 stages): directed vector table, stall/reset sequences
// and random traffic, all checked through an in-order scoreboard fed at operand acceptance.
module tb_pipelined_cla_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
    res_t        exp;
  } vec_t;

  typedef struct {
    res_t exp;
    int   acc;
  } sb_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_miss;
  int   n_pop;
  int   last_lat;
  int   stale;
  int   n_before;
  bit   rnd_on;
  bit   stall_prev;
  logic [31:0] held_sum;
  res_t cur_exp;
  sb_t  sb[$];
  vec_t tbl[14];

  pipelined_cla_addsub_if #(.WIDTH(32)) bus ();

  pipelined_cla_addsub #(
    .WIDTH (32),
    .STAGES(2),
    .BLOCK (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, input logic cin);
    logic [32:0] r;
    res_t        e;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, a} - {1'b0, b};
      2'b10:   r = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      default: r = {1'b0, a} - {1'b0, b} - {32'b0, cin};
    endcase
    e.sum   = r[31:0];
    e.carry = r[32];
    e.ovf   = op[0] ? ((a[31] != b[31]) && (r[31] != a[31]))
                    : ((a[31] == b[31]) && (r[31] != a[31]));
    e.zero  = (r[31:0] == 32'h0);
    e.neg   = r[31];
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                              input logic cin, input logic [31:0] s, input logic c,
                              input logic v, input logic z, input logic n);
    vec_t t;
    t.a   = a;
    t.b   = b;
    t.op  = op;
    t.cin = cin;
    t.exp = {s, c, v, z, n};
    return t;
  endfunction

  function automatic vec_t randVec();
    vec_t t;
    t.a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    t.b   = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
    t.op  = 2'($urandom_range(0, 3));
    t.cin = 1'($urandom_range(0, 1));
    t.exp = model(t.a, t.b, t.op, t.cin);
    return t;
  endfunction

  task automatic checkValue(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input sb_t e);
    res_t got;
    got = {bus.sum, bus.carry, bus.overflow, bus.zero, bus.negative};
    n_vec++;
    n_pop++;
    last_lat = cyc - e.acc;
    if (got !== e.exp) begin
      n_miss++;
      $display("[TB] FAIL result#%0d: got sum=%h c=%b v=%b z=%b n=%b, want sum=%h c=%b v=%b z=%b n=%b",
               n_pop, got.sum, got.carry, got.ovf, got.zero, got.neg,
               e.exp.sum, e.exp.carry, e.exp.ovf, e.exp.zero, e.exp.neg);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic applyStimulus(input vec_t v);
    int tries;
    tries        = 0;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.op       = v.op;
    bus.cin      = v.cin;
    cur_exp      = v.exp;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && tries < 200) begin
      tries++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL accept timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, tries);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    checkValue("drain outstanding", sb.size(), 0);
  endtask

  // Scoreboard: results pop before new beats push, since an output is always older than an input.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("[TB] FAIL unexpected result: got sum=%h with empty scoreboard, want none", bus.sum);
        end else begin
          checkOutput(sb.pop_front());
        end
      end
      if (bus.out_valid && !bus.out_ready) begin
        checkValue("in_ready during stall", int'(bus.in_ready), 0);
        if (stall_prev) begin
          n_vec++;
          if (bus.sum !== held_sum) begin
            n_miss++;
            $display("[TB] FAIL held sum: got %h, want %h", bus.sum, held_sum);
          end
        end
        stall_prev = 1'b1;
        held_sum   = bus.sum;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back('{exp: cur_exp, acc: cyc + 1});
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    n_pop        = 0;
    last_lat     = 0;
    rnd_on       = 1'b0;
    stall_prev   = 1'b0;
    held_sum     = '0;
    cur_exp      = '0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.op       = 2'b00;
    bus.cin      = 1'b0;
    bus.out_ready = 1'b1;

    tbl[0]  = mk(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
    tbl[1]  = mk(32'h0000_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h0001_0000, 0, 0, 0, 0);
    tbl[2]  = mk(32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 32'h7FFF_FFFF, 0, 1, 0, 0);
    tbl[3]  = mk(32'h0000_0005, 32'h0000_0007, 2'b01, 1'b0, 32'hFFFF_FFFE, 1, 0, 0, 1);
    tbl[4]  = mk(32'h0000_0000, 32'h0000_0000, 2'b11, 1'b1, 32'hFFFF_FFFF, 1, 0, 0, 1);
    tbl[5]  = mk(32'h7FFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, 32'h8000_0000, 0, 1, 0, 1);
    tbl[6]  = mk(32'h0000_0001, 32'h0000_0001, 2'b00, 1'b1, 32'h0000_0002, 0, 0, 0, 0);
    tbl[7]  = mk(32'h0000_0007, 32'h0000_0007, 2'b01, 1'b1, 32'h0000_0000, 0, 0, 1, 0);
    tbl[8]  = mk(32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, 32'h0000_0000, 1, 0, 1, 0);
    tbl[9]  = mk(32'h0000_0000, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'h0000_0001, 1, 0, 0, 0);
    tbl[10] = mk(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h8000_0000, 0, 1, 0, 1);
    tbl[11] = mk(32'h8000_0000, 32'h0000_0000, 2'b11, 1'b1, 32'h7FFF_FFFF, 0, 1, 0, 0);
    tbl[12] = mk(32'h0000_FFFF, 32'hFFFF_0000, 2'b10, 1'b1, 32'h0000_0000, 1, 0, 1, 0);
    tbl[13] = mk(32'h0001_0000, 32'h0000_0001, 2'b01, 1'b0, 32'h0000_FFFF, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    checkValue("reset out_valid", int'(bus.out_valid), 0);
    checkValue("reset in_ready", int'(bus.in_ready), 1);
    checkValue("reset sum", int'(bus.sum), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single beat latency");
    applyStimulus(tbl[0]);
    drain();
    checkValue("latency single", last_lat, 2);

    $display("[TB] directed vector table, back to back");
    for (int i = 1; i < 14; i++) applyStimulus(tbl[i]);
    drain();

    $display("[TB] six beats with output stall");
    n_before = n_pop;
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(randVec());
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    checkValue("stall beat count", n_pop - n_before, 6);

    $display("[TB] reset with beats in flight");
    bus.out_ready = 1'b0;
    applyStimulus(randVec());
    applyStimulus(randVec());
    @(posedge clk);
    #2;
    checkValue("pre-reset out_valid", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    checkValue("reset out_valid drop", int'(bus.out_valid), 0);
    checkValue("reset in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    stale         = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    checkValue("stale results", stale, 0);
    @(posedge clk);
    #1;
    applyStimulus(tbl[2]);
    drain();
    checkValue("latency after reset", last_lat, 2);

    $display("[TB] random traffic with random backpressure");
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          applyStimulus(randVec());
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_on = 1'b0;
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
